mem_access: RTL and testbench

Memory-access stage placed directly downstream of `alu`. It takes the ALU-computed effective address plus the store data for a load/store and drives a request/acknowledge handshake to the data SRAM port. It generates byte lanes and store-data replication, then sign- or zero-extends the returned load data. It stalls the pipeline until the access completes.

---
 rtl/mem_access.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: load/store stage between the ALU and the data SRAM port.
// Builds byte enables and lane-replicated store data, runs a req/ack
// handshake with the SRAM, and sign/zero-extends returned load data.
// The upstream pipeline is stalled until the access completes.
// Optional feature macro: MEM_ADDR_EXCEPT_EN. When defined, misaligned
// accesses issue no request and raise adel_o/ades_o with badvaddr_o.
// When undefined, the low address bits are used as-is.
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // only 32 is supported: lanes are fixed at 4 bytes
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [7:0]        alucontrol_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic [3:0]        mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              adel_o,
    output logic              ades_o,
    output logic [ADDR_W-1:0] badvaddr_o
);

    // Load/store opcodes shared with the ALU decode (EXE_*_OP).
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;

    state_e state_q, state_d;

    // Decoded view of the incoming instruction
    logic              is_load;
    logic              is_store;
    logic              sext;
    size_e             size;
    logic              memop;
    logic              misaligned;
    logic              start;
    logic [1:0]        lane;
    logic [3:0]        wen_n;
    logic [DATA_W-1:0] wdata_n;

    // Access latched at accept time and held through BUSY
    logic              load_q;
    logic              sext_q;
    size_e             size_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic              capture;

    // Completion side
    logic              kill_q, kill_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;

    assign lane = addr_i[1:0];

    // Classify the ALU opcode into access direction, size and extension.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        size     = SZ_W;
        case (alucontrol_i)
            EXE_LB_OP:  begin is_load  = 1'b1; sext = 1'b1; size = SZ_B; end
            EXE_LBU_OP: begin is_load  = 1'b1;              size = SZ_B; end
            EXE_LH_OP:  begin is_load  = 1'b1; sext = 1'b1; size = SZ_H; end
            EXE_LHU_OP: begin is_load  = 1'b1;              size = SZ_H; end
            EXE_LW_OP:  begin is_load  = 1'b1;              size = SZ_W; end
            EXE_SB_OP:  begin is_store = 1'b1;              size = SZ_B; end
            EXE_SH_OP:  begin is_store = 1'b1;              size = SZ_H; end
            EXE_SW_OP:  begin is_store = 1'b1;              size = SZ_W; end
            default:    ;
        endcase
    end

    assign memop = is_load | is_store;

`ifdef MEM_ADDR_EXCEPT_EN
    assign misaligned = ((size == SZ_W) && (lane != 2'b00)) ||
                        ((size == SZ_H) && lane[0]);
`else
    assign misaligned = 1'b0;
`endif

    assign start = valid_i & memop & ~flush_i & ~misaligned;

    // Byte enables and lane-replicated store data; loads write nothing.
    always_comb begin
        wen_n   = 4'b0000;
        wdata_n = wdata_i;
        if (is_store) begin
            case (size)
                SZ_B: begin
                    wen_n   = 4'b0001 << lane;
                    wdata_n = {4{wdata_i[7:0]}};
                end
                SZ_H: begin
                    wen_n   = lane[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{wdata_i[15:0]}};
                end
                default: wen_n = 4'b1111;
            endcase
        end
    end

    // Pick the addressed byte/halfword from the returned word and extend it.
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            SZ_B:    ld_ext = sext_q ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
            SZ_H:    ld_ext = sext_q ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    // Next state, stall, and completion decisions.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        capture = 1'b0;
        kill_d  = kill_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stall_o = 1'b1;
                    capture = 1'b1;
                    kill_d  = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // An issued request cannot be withdrawn; a flush only hides its result.
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (mem_ack_i) begin
                    state_d = IDLE;
                    if (!(kill_q || flush_i)) begin
                        done_d = 1'b1;
                        if (load_q) begin
                            rdata_d = ld_ext;
                        end
                    end
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Access latch and completion registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset as well, because the SRAM-side and result outputs they drive must read 0 after reset.
            load_q  <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= SZ_B;
            lane_q  <= 2'b00;
            addr_q  <= '0;
            wen_q   <= 4'b0000;
            wdata_q <= '0;
            kill_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (capture) begin
                load_q  <= is_load;
                sext_q  <= sext;
                size_q  <= size;
                lane_q  <= lane;
                addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                wen_q   <= wen_n;
                wdata_q <= wdata_n;
            end
            kill_q  <= kill_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_req_o   = (state_q == BUSY);
    assign mem_wen_o   = wen_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;

`ifdef MEM_ADDR_EXCEPT_EN
    logic              exc_fire;
    logic              adel_q;
    logic              ades_q;
    logic [ADDR_W-1:0] badvaddr_q;

    // Only an instruction arriving in IDLE can fault; BUSY holds the accepted one.
    assign exc_fire = (state_q == IDLE) & valid_i & memop & ~flush_i & misaligned;

    // One-cycle address-error pulses with the faulting address held.
    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            badvaddr_q <= '0;
        end else begin
            adel_q <= exc_fire & is_load;
            ades_q <= exc_fire & is_store;
            if (exc_fire) begin
                badvaddr_q <= addr_i;
            end
        end
    end

    assign adel_o     = adel_q;
    assign ades_o     = ades_q;
    assign badvaddr_o = badvaddr_q;
`else
    assign adel_o     = 1'b0;
    assign ades_o     = 1'b0;
    assign badvaddr_o = '0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for mem_access with an SRAM
// responder and a byte-level reference memory.
module tb_mem_access;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_OR  = 8'h25;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [7:0]  alucontrol_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic [3:0]  mem_wen_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .alucontrol_i (alucontrol_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_wen_o    (mem_wen_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .adel_o       (adel_o),
        .ades_o       (ades_o),
        .badvaddr_o   (badvaddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entries
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        bit          is_store;
    } req_t;
    typedef struct {
        int          cyc;
        bit          is_load;
        logic [31:0] rdata;
    } done_t;
    typedef struct {
        int          cyc;
        bit          is_load;
        logic [31:0] badv;
    } exc_t;

    req_t  req_q[$];
    done_t done_q[$];
    exc_t  exc_q[$];

    int total = 0;
    int bad   = 0;
    logic [31:0] model_rdata = 32'h0;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] sram    [logic [31:0]];

    int resp_en = 1;
    int lat_cfg = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Contents of words never written: a fixed scramble of the word address.
    function automatic logic [31:0] def_word(input logic [31:0] wa);
        return wa * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : def_word(wa);
    endfunction

    function automatic logic [31:0] sram_rd(input logic [31:0] wa);
        return sram.exists(wa) ? sram[wa] : def_word(wa);
    endfunction

    function automatic int op_bytes(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic bit op_signed(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic bit is_misaligned(input logic [7:0] op, input logic [1:0] a);
`ifdef MEM_ADDR_EXCEPT_EN
        int n;
        n = op_bytes(op);
        return (n > 1) && ((int'(a) % n) != 0);
`else
        return (op_bytes(op) < 0) && (a != 2'b00);
`endif
    endfunction

    // Issue one instruction and hold it until the stage releases it.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input bit v, input bit fl_idle, input int lat, input int fl_cyc);
        int          n;
        int          off;
        bit          access;
        bit          kill;
        int          stall_cnt;
        int          budget;
        logic [31:0] mask;
        logic [31:0] rep;
        logic [31:0] word;
        logic [31:0] ld;
        logic [3:0]  wen;
        logic [31:0] wa;
        lat_cfg = lat;
        @(negedge clk);
        valid_i      = v;
        alucontrol_i = op;
        addr_i       = a;
        wdata_i      = wd;
        flush_i      = fl_idle;
        n      = op_bytes(op);
        access = v && (n != 0) && !fl_idle && !is_misaligned(op, a[1:0]);
        if (v && (n != 0) && !fl_idle && is_misaligned(op, a[1:0]))
            exc_q.push_back('{cyc + 1, op_is_load(op), a});
        ld = 32'h0;
        if (access) begin
            wa   = a & 32'hFFFF_FFFC;
            off  = (int'(a[1:0]) / n) * n;
            mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
            rep  = 32'h0;
            for (int k = 0; k < 4 / n; k++) rep = rep | ((wd & mask) << (8 * n * k));
            wen  = op_is_load(op) ? 4'b0000 : 4'(((1 << n) - 1) << off);
            word = ref_rd(wa);
            ld   = (word >> (8 * off)) & mask;
            if (op_signed(op) && ld[8 * n - 1]) ld = ld | ~mask;
            req_q.push_back('{wa, wen, rep, !op_is_load(op)});
            for (int i = 0; i < 4; i++)
                if (wen[i]) word[8 * i +: 8] = rep[8 * i +: 8];
            ref_mem[wa] = word;
        end
        #1;
        check("stall_at_accept", 32'(stall_o), 32'(access));
        if (!access) return;
        stall_cnt = 1;
        budget    = 0;
        kill      = 1'b0;
        while (1) begin
            @(negedge clk);
            budget++;
            flush_i = (budget == fl_cyc);
            if (flush_i) kill = 1'b1;
            #1;
            if (!stall_o) break;
            stall_cnt++;
            if (budget > 200) begin
                check("stall_timeout", 32'(stall_o), 32'h0);
                break;
            end
        end
        check("stall_cycles", 32'(stall_cnt), 32'(lat));
        if (!kill) done_q.push_back('{cyc + 1, op_is_load(op), ld});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            flush_i = 1'b0;
        end
    endtask

    // SRAM responder: acks after lat_cfg request cycles, applies byte writes.
    initial begin : responder
        int          rcnt;
        logic [31:0] w;
        rcnt = 0;
        forever begin
            @(negedge clk);
            if (resp_en != 0) begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = $urandom;
                if (mem_req_o && !rst) begin
                    rcnt++;
                    if (rcnt >= lat_cfg) begin
                        mem_ack_i   = 1'b1;
                        mem_rdata_i = sram_rd(mem_addr_o);
                        w = mem_rdata_i;
                        for (int i = 0; i < 4; i++)
                            if (mem_wen_o[i]) w[8 * i +: 8] = mem_wdata_o[8 * i +: 8];
                        sram[mem_addr_o] = w;
                        rcnt = 0;
                    end
                end else begin
                    rcnt = 0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request, completion or exception.
    initial begin : monitor
        bit          req_active;
        bit          prev_done;
        logic [31:0] cur_addr;
        logic [3:0]  cur_wen;
        logic [31:0] cur_wdata;
        req_t        r;
        done_t       d;
        exc_t        e;
        req_active = 1'b0;
        prev_done  = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                req_active = 1'b0;
                prev_done  = 1'b0;
                continue;
            end
            if (mem_req_o) begin
                if (!req_active) begin
                    req_active = 1'b1;
                    cur_addr   = mem_addr_o;
                    cur_wen    = mem_wen_o;
                    cur_wdata  = mem_wdata_o;
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 32'(mem_req_o), 32'h0);
                    end else begin
                        r = req_q.pop_front();
                        check("req_addr", mem_addr_o, r.addr);
                        check("req_wen", 32'(mem_wen_o), 32'(r.wen));
                        if (r.is_store) check("req_wdata", mem_wdata_o, r.wdata);
                    end
                end else begin
                    check("req_addr_stable", mem_addr_o, cur_addr);
                    check("req_wen_stable", 32'(mem_wen_o), 32'(cur_wen));
                    check("req_wdata_stable", mem_wdata_o, cur_wdata);
                end
            end else begin
                req_active = 1'b0;
            end
            if (done_o) begin
                check("done_back_to_back", 32'(prev_done), 32'h0);
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'(done_o), 32'h0);
                end else begin
                    d = done_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(d.cyc));
                    if (d.is_load) model_rdata = d.rdata;
                end
            end else if (done_q.size() != 0 && done_q[0].cyc < cyc) begin
                check("missing_done", 32'(done_o), 32'h1);
                void'(done_q.pop_front());
            end
            prev_done = done_o;
            check("rdata", rdata_o, model_rdata);
            if (adel_o || ades_o) begin
                if (exc_q.size() == 0) begin
                    check("unexpected_exc", 32'({adel_o, ades_o}), 32'h0);
                end else begin
                    e = exc_q.pop_front();
                    check("exc_cycle", 32'(cyc), 32'(e.cyc));
                    check("adel", 32'(adel_o), 32'(e.is_load));
                    check("ades", 32'(ades_o), 32'(!e.is_load));
                    check("badvaddr", badvaddr_o, e.badv);
                end
            end else if (exc_q.size() != 0 && exc_q[0].cyc < cyc) begin
                check("missing_exc", 32'({adel_o, ades_o}), 32'h1);
                void'(exc_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [7:0] ops [10];
        logic [7:0] op;
        int         lat;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADD, OP_OR};

        rst          = 1'b1;
        valid_i      = 1'b0;
        alucontrol_i = 8'h00;
        addr_i       = 32'h0;
        wdata_i      = 32'h0;
        flush_i      = 1'b0;
        mem_ack_i    = 1'b0;
        mem_rdata_i  = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_req", 32'(mem_req_o), 32'h0);
        check("reset_done", 32'(done_o), 32'h0);
        check("reset_rdata", rdata_o, 32'h0);
        check("reset_addr", mem_addr_o, 32'h0);
        check("reset_stall", 32'(stall_o), 32'h0);

        // SB with two-cycle ack: byte 3 of word 0x1000, data replicated.
        issue(OP_SB, 32'h0000_1003, 32'h0000_00A5, 1, 0, 2, 0);

        // Known word for the extraction cases.
        ref_mem[32'h2000] = 32'h1234_F6AB;
        sram[32'h2000]    = 32'h1234_F6AB;
        issue(OP_LB, 32'h0000_2001, 32'h0, 1, 0, 1, 0);
        @(negedge clk); valid_i = 1'b0; #1;
        check("lb_sign_ext", rdata_o, 32'hFFFF_FFF6);
        issue(OP_LBU, 32'h0000_2001, 32'h0, 1, 0, 2, 0);
        @(negedge clk); valid_i = 1'b0; #1;
        check("lbu_zero_ext", rdata_o, 32'h0000_00F6);
        issue(OP_LHU, 32'h0000_2002, 32'h0, 1, 0, 1, 0);
        @(negedge clk); valid_i = 1'b0; #1;
        check("lhu_zero_ext", rdata_o, 32'h0000_1234);

        // LW with ack held low for 5 cycles.
        issue(OP_LW, 32'h0000_1010, 32'h0, 1, 0, 6, 0);

        // Flush while BUSY: request completes, result hidden.
        issue(OP_LW, 32'h0000_1020, 32'h0, 1, 0, 3, 2);
        @(negedge clk); valid_i = 1'b0; #1;
        check("flush_busy_no_done", 32'(done_o), 32'h0);

        // Misaligned LW.
        ref_mem[32'h3000] = 32'hCAFE_F00D;
        sram[32'h3000]    = 32'hCAFE_F00D;
        issue(OP_LW, 32'h0000_3002, 32'h0, 1, 0, 1, 0);
        @(negedge clk); valid_i = 1'b0; #1;
`ifdef MEM_ADDR_EXCEPT_EN
        check("misaligned_adel", 32'(adel_o), 32'h1);
        check("misaligned_badv", badvaddr_o, 32'h0000_3002);
`else
        check("misaligned_lw_word", rdata_o, 32'hCAFE_F00D);
`endif
        idle(2);

        // Reset during BUSY, then a late ack.
        lat_cfg = 50;
        @(negedge clk);
        valid_i = 1'b1; alucontrol_i = OP_LW; addr_i = 32'h0000_1030; flush_i = 1'b0;
        req_q.push_back('{32'h0000_1030, 4'b0000, 32'h0, 1'b0});
        #1;
        check("rst_test_accept", 32'(stall_o), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1; valid_i = 1'b0; model_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0; resp_en = 0;
        #1;
        check("rst_busy_req", 32'(mem_req_o), 32'h0);
        check("rst_busy_addr", mem_addr_o, 32'h0);
        check("rst_busy_wen", 32'(mem_wen_o), 32'h0);
        check("rst_busy_wdata", mem_wdata_o, 32'h0);
        check("rst_busy_rdata", rdata_o, 32'h0);
        check("rst_busy_exc", 32'({adel_o, ades_o}), 32'h0);
        check("rst_busy_badv", badvaddr_o, 32'h0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        check("late_ack_no_done", 32'(done_o), 32'h0);
        check("late_ack_no_req", 32'(mem_req_o), 32'h0);
        @(negedge clk);
        #1;
        check("late_ack_no_done2", 32'(done_o), 32'h0);
        resp_en = 1;

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            op  = ops[$urandom_range(0, 9)];
            lat = $urandom_range(1, 4);
            issue(op, 32'h0000_1000 + 32'($urandom_range(0, 63)), $urandom,
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), lat,
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, lat) : 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(4);
        check("req_queue_drained", 32'(req_q.size()), 32'h0);
        check("done_queue_drained", 32'(done_q.size()), 32'h0);
        check("exc_queue_drained", 32'(exc_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
